// File: rtl/if_id_buffer_pkg.sv
// Shared pipeline types for the fetch/decode boundary: NOP encoding and the buffered entry layout.
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] ins;
   } if_id_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for if_id_buffer; master is the fetch+decode side, slave is the buffer.
interface if_id_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32,
   parameter int DEPTH      = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  flush;
   logic                  valid_f;
   logic                  ready_f;
   logic [PC_WIDTH-1:0]   pc_f;
   logic [PC_WIDTH-1:0]   pc_plus4_f;
   logic [DATA_WIDTH-1:0] ins_f;
   logic                  valid_d;
   logic                  ready_d;
   logic [PC_WIDTH-1:0]   pc_d;
   logic [PC_WIDTH-1:0]   pc_plus4_d;
   logic [DATA_WIDTH-1:0] ins_d;
   logic [CW-1:0]         count;

   modport master (
      output flush, valid_f, pc_f, pc_plus4_f, ins_f, ready_d,
      input  ready_f, valid_d, pc_d, pc_plus4_d, ins_d, count
   );

   modport slave (
      input  flush, valid_f, pc_f, pc_plus4_f, ins_f, ready_d,
      output ready_f, valid_d, pc_d, pc_plus4_d, ins_d, count
   );
endinterface

// File: rtl/if_id_buffer_mem.sv
// if_id_mem: DEPTH-entry register array, one synchronous write port, one combinational read port.
module if_id_mem #(
   parameter int  DEPTH   = 2,
   parameter type entry_t = pipeline_pkg::if_id_t,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);
   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO with flush; IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_buffer
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32,
   parameter int DEPTH      = 2
) (
   input  logic           clk,
   input  logic           rst,
   if_id_buffer_if.slave  bus
`ifdef IF_ID_PERF_EN
   ,
   output logic [31:0]    stall_cnt,
   output logic [31:0]    flush_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [PC_WIDTH-1:0]   pc_plus4;
      logic [DATA_WIDTH-1:0] ins;
   } entry_t;

   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty, push, pop;
   entry_t      wdata, head;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   assign bus.ready_f = ~full & ~rst;
   assign bus.valid_d = ~empty;
   assign push = bus.valid_f & bus.ready_f & ~bus.flush;
   assign pop  = bus.valid_d & bus.ready_d & ~bus.flush;
   assign bus.count = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign wdata = '{pc: bus.pc_f, pc_plus4: bus.pc_plus4_f, ins: bus.ins_f};

   if_id_mem #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );

   always_comb begin
      bus.pc_d       = '0;
      bus.pc_plus4_d = '0;
      bus.ins_d      = DATA_WIDTH'(NOP_INSTR);
      if (!empty) begin
         bus.pc_d       = head.pc;
         bus.pc_plus4_d = head.pc_plus4;
         bus.ins_d      = head.ins;
      end
   end

`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.valid_f && !bus.ready_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (bus.flush && !empty && flush_cnt != '1)         flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif
endmodule
